// File: rtl/alu_stim_driver.sv
// alu_stim_driver: on-chip self-test initiator for an 8-bit ALU operand interface.
// Sweeps every opcode per operand pair, reloads operands from a 16-bit LFSR after
// each sweep, captures each ALU result and hands it downstream on valid/ready
// while folding accepted results into a rotating checksum.
// Ports:
//   clk, rst_n             clock (rising edge), async active-low reset
//   start, stop            run control pulses
//   a_in, b_in, op         registered ALU operands / opcode
//   alu_res                combinational ALU result for a_in/b_in/op
//   res_valid, res_ready   result handshake
//   res_data/op/a/b        captured result and the inputs that produced it
//   busy, done             run status
//   sweep_cnt, checksum    completed sweeps and running checksum of this run
module alu_stim_driver #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned OP_W       = 4,
  parameter int unsigned RES_W      = 16,
  parameter int unsigned OP_HOLD    = 1,
  parameter int unsigned NUM_SWEEPS = 4,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] a_in,
  output logic [WIDTH-1:0] b_in,
  output logic [OP_W-1:0]  op,
  input  logic [RES_W-1:0] alu_res,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [RES_W-1:0] res_data,
  output logic [OP_W-1:0]  res_op,
  output logic [WIDTH-1:0] res_a,
  output logic [WIDTH-1:0] res_b,
  output logic             busy,
  output logic             done,
  output logic [15:0]      sweep_cnt,
  output logic [15:0]      checksum
);

  localparam int unsigned       HOLD_W    = (OP_HOLD > 1) ? $clog2(OP_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = (OP_HOLD > 1) ? HOLD_W'(OP_HOLD - 1) : '0;
  localparam logic [OP_W-1:0]   OP_MAX    = {OP_W{1'b1}};
  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [15:0]       SEED      = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  typedef enum logic [1:0] {IDLE, DRIVE, RESP, DONE} state_e;

  state_e             state_q, state_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               stop_pend_q, stop_pend_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [OP_W-1:0]    op_q, op_d;
  logic               res_valid_q, res_valid_d;
  logic [RES_W-1:0]   res_data_q, res_data_d;
  logic [OP_W-1:0]    res_op_q, res_op_d;
  logic [WIDTH-1:0]   res_a_q, res_a_d, res_b_q, res_b_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [15:0]        sweep_q, sweep_d;
  logic [15:0]        cks_q, cks_d;
  logic [15:0]        lfsr_nx;
  logic               end_run;

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1, right-shifting form.
  assign lfsr_nx = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    hold_d      = hold_q;
    stop_pend_d = stop_pend_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_op_d    = res_op_q;
    res_a_d     = res_a_q;
    res_b_d     = res_b_q;
    done_d      = done_q;
    sweep_d     = sweep_q;
    cks_d       = cks_q;
    end_run     = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d         = WIDTH'(lfsr_q[7:0]);
          b_d         = WIDTH'(lfsr_q[15:8]);
          op_d        = '0;
          sweep_d     = '0;
          cks_d       = '0;
          done_d      = 1'b0;
          stop_pend_d = 1'b0;
          hold_d      = '0;
          state_d     = DRIVE;
        end
      end
      DRIVE: begin
        if (stop) stop_pend_d = 1'b1;
        if (hold_q == HOLD_LAST) begin
          res_data_d  = alu_res;
          res_op_d    = op_q;
          res_a_d     = a_q;
          res_b_d     = b_q;
          res_valid_d = 1'b1;
          hold_d      = '0;
          state_d     = RESP;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      RESP: begin
        if (stop) stop_pend_d = 1'b1;
        if (res_ready) begin
          cks_d       = {cks_q[14:0], cks_q[15]} ^ 16'(res_data_q);
          res_valid_d = 1'b0;
          // A stop seen in the accepting cycle ends the run at this accept too.
          if (op_q != OP_MAX) begin
            op_d    = op_q + OP_W'(1);
            end_run = stop_pend_q | stop;
          end else begin
            op_d    = '0;
            sweep_d = (sweep_q == 16'hFFFF) ? sweep_q : sweep_q + 16'd1;
            lfsr_d  = lfsr_nx;
            a_d     = WIDTH'(lfsr_nx[7:0]);
            b_d     = WIDTH'(lfsr_nx[15:8]);
            end_run = ((NUM_SWEEPS != 0) && ((32'(sweep_q) + 32'd1) == NUM_SWEEPS))
                      | stop_pend_q | stop;
          end
          if (end_run) begin
            state_d     = DONE;
            done_d      = 1'b1;
            stop_pend_d = 1'b0;
          end else begin
            state_d = DRIVE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == DRIVE) || (state_d == RESP);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lfsr_q      <= SEED;
      hold_q      <= '0;
      stop_pend_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_op_q    <= '0;
      res_a_q     <= '0;
      res_b_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sweep_q     <= '0;
      cks_q       <= '0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      hold_q      <= hold_d;
      stop_pend_q <= stop_pend_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_op_q    <= res_op_d;
      res_a_q     <= res_a_d;
      res_b_q     <= res_b_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      sweep_q     <= sweep_d;
      cks_q       <= cks_d;
    end
  end

  assign a_in      = a_q;
  assign b_in      = b_q;
  assign op        = op_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_op    = res_op_q;
  assign res_a     = res_a_q;
  assign res_b     = res_b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign sweep_cnt = sweep_q;
  assign checksum  = cks_q;

endmodule

// File: tb/tb_alu_stim_driver.sv
// Bench for alu_stim_driver: ALU modelled as a + b + op, result sink with
// random ready, reference model tracking the expected operand/opcode sequence.
module tb_alu_stim_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stop;
  logic [7:0]  a_in, b_in;
  logic [3:0]  op;
  logic [15:0] alu_res;
  logic        res_valid, res_ready;
  logic [15:0] res_data;
  logic [3:0]  res_op;
  logic [7:0]  res_a, res_b;
  logic        busy, done;
  logic [15:0] sweep_cnt, checksum;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int unsigned m_lfsr, m_a, m_b, m_op, m_sweeps, m_cks, run_acc;

  always #5 clk = ~clk;

  assign alu_res = 16'(a_in) + 16'(b_in) + 16'(op);

  alu_stim_driver #(
    .WIDTH(8), .OP_W(4), .RES_W(16), .OP_HOLD(1), .NUM_SWEEPS(2), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .a_in(a_in), .b_in(b_in), .op(op), .alu_res(alu_res),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_op(res_op), .res_a(res_a), .res_b(res_b),
    .busy(busy), .done(done), .sweep_cnt(sweep_cnt), .checksum(checksum)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned lfsr_step(input int unsigned l);
    int unsigned fb;
    fb = ((l >> 0) ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 1;
    return (l >> 1) | (fb << 15);
  endfunction

  task automatic model_start();
    m_a      = m_lfsr & 8'hFF;
    m_b      = (m_lfsr >> 8) & 8'hFF;
    m_op     = 0;
    m_sweeps = 0;
    m_cks    = 0;
    run_acc  = 0;
  endtask

  task automatic model_accept();
    int unsigned data;
    data  = (m_a + m_b + m_op) & 16'hFFFF;
    m_cks = (((m_cks << 1) | (m_cks >> 15)) & 16'hFFFF) ^ data;
    run_acc++;
    if (m_op == 15) begin
      m_op = 0;
      m_sweeps++;
      m_lfsr = lfsr_step(m_lfsr);
      m_a = m_lfsr & 8'hFF;
      m_b = (m_lfsr >> 8) & 8'hFF;
    end else begin
      m_op++;
    end
  endtask

  // One clock: inspect any offered result mid-cycle, then step past the edge.
  task automatic cycle();
    bit acc;
    acc = 1'b0;
    @(negedge clk);
    if (res_valid) begin
      chk("res_op", res_op, m_op);
      chk("res_a", res_a, m_a);
      chk("res_b", res_b, m_b);
      chk("res_data", res_data, (m_a + m_b + m_op) & 16'hFFFF);
      chk("op_held", op, m_op);
      if (res_ready) begin
        acc = 1'b1;
        model_accept();
      end
    end
    @(posedge clk);
    #1;
    if (acc) begin
      chk("post_op", op, m_op);
      chk("post_a_in", a_in, m_a);
      chk("post_b_in", b_in, m_b);
      chk("post_sweep_cnt", sweep_cnt, m_sweeps);
      chk("post_checksum", checksum, m_cks);
    end
  endtask

  task automatic do_start(input bit with_stop);
    start = 1'b1;
    stop  = with_stop;
    model_start();
    cycle();
    start = 1'b0;
    stop  = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_done", done, 0);
    chk("start_a_in", a_in, m_a);
    chk("start_b_in", b_in, m_b);
    chk("start_op", op, 0);
    chk("start_sweep_cnt", sweep_cnt, 0);
    chk("start_checksum", checksum, 0);
  endtask

  initial begin
    int n;
    bit start_sent, stop_sent;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; res_ready = 1'b0;
    m_lfsr = 16'hACE1;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_in", a_in, 0);      chk("rst_b_in", b_in, 0);
    chk("rst_op", op, 0);          chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_op", res_op, 0);  chk("rst_res_a", res_a, 0);
    chk("rst_res_b", res_b, 0);    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);      chk("rst_sweep_cnt", sweep_cnt, 0);
    chk("rst_checksum", checksum, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset asserted mid-DRIVE, then a fresh start reloads the seed operands
    do_start(1'b0);
    chk("seed_a_in", a_in, 8'hE1);
    chk("seed_b_in", b_in, 8'hAC);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);   chk("midrst_a_in", a_in, 0);
    chk("midrst_b_in", b_in, 0);   chk("midrst_res_valid", res_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_lfsr = 16'hACE1;
    @(posedge clk);
    #1;
    do_start(1'b0);
    chk("reseed_a_in", a_in, 8'hE1);
    chk("reseed_b_in", b_in, 8'hAC);

    // Full-rate run: two sweeps, one result every two cycles
    res_ready = 1'b1;
    n = 0;
    while (!done && n < 300) begin
      cycle();
      n++;
    end
    chk("run1_latency", n, 64);
    chk("run1_results", run_acc, 32);
    chk("run1_busy", busy, 0);
    chk("run1_sweep_cnt", sweep_cnt, 2);
    chk("run1_checksum", checksum, m_cks);
    chk("run1_res_valid", res_valid, 0);

    // stop in DONE is ignored; start+stop together: start wins, full run follows
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    chk("stop_in_done", done, 1);
    do_start(1'b1);
    n = 0;
    while (!(res_valid && res_op == 4'd3) && n < 100) begin
      cycle();
      n++;
    end
    chk("bp_reach_op3", (n < 100), 1);
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("bp_valid", res_valid, 1);
      chk("bp_op", op, 3);
    end
    n = 0;
    while (!done && n < 1000) begin
      res_ready = 1'($urandom_range(0, 1));
      cycle();
      n++;
    end
    chk("run2_done", done, 1);
    chk("run2_results", run_acc, 32);
    chk("run2_sweep_cnt", sweep_cnt, 2);
    chk("run2_checksum", checksum, m_cks);

    // Mid-sweep stop at op 6, with an ignored start while busy
    do_start(1'b0);
    n = 0; start_sent = 1'b0; stop_sent = 1'b0;
    while (!done && n < 1000) begin
      res_ready = 1'($urandom_range(0, 1));
      start = !start_sent && (op == 4'd2);
      if (start) start_sent = 1'b1;
      stop = !stop_sent && (op == 4'd6) && !res_valid;
      if (stop) stop_sent = 1'b1;
      cycle();
      n++;
    end
    start = 1'b0; stop = 1'b0;
    chk("stop_done", done, 1);
    chk("stop_results", run_acc, 7);
    chk("stop_op", op, 7);
    chk("stop_sweep_cnt", sweep_cnt, 0);
    chk("stop_checksum", checksum, m_cks);
    chk("stop_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
